hack_cpu_core: RTL and testbench
================================

# hack_cpu_core

- Single-clock, Hack-ISA-compatible CPU datapath and control that executes one instruction per enabled cycle.
- Owns the A, D and PC registers and decodes each 16-bit instruction.
- Drives the team's existing combinational `alu` (zx, nx, zy, ny, f, no in; ng, zr out) and consumes its flags for branch resolution.
- Sits between instruction ROM and data RAM; it is the control-side partner of the ALU.

## Interface

Parameters:
- none; all datapaths are fixed at 16 bits.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `en`  in  1  — step enable; when 0, no architectural state changes.
- `instruction`  in  16  — instruction word fetched from ROM at address `pc`.
- `inM`  in  16  — RAM read data at `addressM`.
- `outM`  out  16  — ALU result (write data for RAM).
- `writeM`  out  1  — RAM write strobe for the current cycle.
- `addressM`  out  16  — RAM address; equals the current A register.
- `pc`  out  16  — address of the instruction being executed.

## Operation

Instruction decode:
- `instruction[15]=0` (A-instruction): on the next enabled edge, A is loaded with `{1'b0, instruction[14:0]}`. No other register changes except `pc`. `writeM=0`.
- `instruction[15]=1` (C-instruction): fields are
  - `a`=[12], the ALU y-operand select;
  - zx,nx,zy,ny,f,no = [11:6];
  - dest d1(A), d2(D), d3(M) = [5:3];
  - jump j1(lt), j2(eq), j3(gt) = [2:0];
  - bits [14:13] are ignored.

ALU connection:
- x = D.
- y = `inM` when a=1, otherwise A.
- Control bits pass straight from the instruction.
- A-instructions still drive the ALU; the result is don't-care and `writeM` is 0.

Outputs:
- `outM` = ALU output, combinational, every cycle.
- `writeM` = `rst_n & en & instruction[15] & d3`.
- `addressM` = A register value before the edge.

Destinations (C-instruction, enabled edge):
- d1 → A ← outM.
- d2 → D ← outM.
- d1 and d2 may both be set; each register receives outM independently.

Jump resolution:
- jump = C-instruction & ((j1 & ng) | (j2 & zr) | (j3 & ~ng & ~zr)).
- If jump: `pc` ← A value before the edge. This holds even when the same instruction writes A.
- Otherwise `pc` ← `pc+1`, mod 2^16 (0xFFFF wraps to 0x0000).

Enable and reset:
- `en=0`: A, D and `pc` hold; `writeM=0`; `outM` and `addressM` remain live.
- Reset: while `rst_n=0`, A, D and `pc` are 0x0000 and `writeM=0`.
- Reset asserted mid-instruction takes effect immediately and asynchronously. The partial instruction is discarded.
- After `rst_n` rises, the first enabled edge executes the instruction at `pc=0`.

## Timing

- Latency: one cycle per instruction. All register updates happen on the rising `clk` edge with `en=1`.
- Combinational paths to outputs:
  - `instruction`/`inM`/A/D → `outM`, `writeM`;
  - A → `addressM`.
  - RAM must capture `outM` at `addressM` on the same edge when `writeM=1`.
- `inM` must be valid for the current `addressM` within the cycle (asynchronous-read RAM).
- Reset values: `pc`=0x0000, `addressM`=0x0000, `writeM`=0. `outM` is whatever the ALU produces with D=0, A=0 and the current instruction.
- No multi-cycle states and no internal handshake. `en` is the only stall mechanism and may toggle on any cycle.

## Test plan

1. **Reset mid-run.** Preload A=0x1234, D=0x0042, pc=5; pull `rst_n` low between edges. A, D and pc read 0x0000 immediately and `writeM=0`. Release reset; the next edge gives pc=1.
2. **A then D load.** Execute 0x0015 (@21), then 0xEC10 (D=A). Expect A=21, D=21, pc=2, `writeM=0` throughout.
3. **Memory write.** With A=100, D=21, execute 0xE7C8 (M=D+1). In-cycle: `outM`=22, `writeM`=1, `addressM`=100. After the edge, A and D are unchanged and pc has incremented.
4. **Conditional jump.**
   - With A=40, D=0xFFFF, execute 0xE301 (D;JGT): pc increments.
   - With D=5: pc=40.
   - 0xEA87 (0;JMP) with A=0x0123: pc=0x0123.
5. **Simultaneous dest-A + jump.** A=7, inM=1, execute 0xFCAA (AM=M-1;JEQ). In-cycle: outM=0, writeM=1, addressM=7. After the edge: pc=7 (old A), A=0.
6. **Stall and wrap.**
   - Hold `en=0` for 3 edges under 0xEC10: A, D, pc unchanged and `writeM=0` while stalled.
   - Run to pc=0xFFFF with a non-jump instruction: next pc=0x0000.

Source files
------------

// File: rtl/hack_cpu_core.sv
// Hack-ISA CPU core: owns the A, D and PC registers, decodes each instruction
// and drives a combinational Hack ALU. One instruction per enabled clock edge.

module alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);
  logic [15:0] w_x_z;
  logic [15:0] w_x_n;
  logic [15:0] w_y_z;
  logic [15:0] w_y_n;
  logic [15:0] w_res;

  assign w_x_z = zx ? 16'h0000 : x;
  assign w_x_n = nx ? ~w_x_z : w_x_z;
  assign w_y_z = zy ? 16'h0000 : y;
  assign w_y_n = ny ? ~w_y_z : w_y_z;
  assign w_res = f ? (w_x_n + w_y_n) : (w_x_n & w_y_n);
  assign out   = no ? ~w_res : w_res;
  assign zr    = (out == 16'h0000);
  assign ng    = out[15];
endmodule

module hack_cpu_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] instruction,
  input  logic [15:0] inM,
  output logic [15:0] outM,
  output logic        writeM,
  output logic [15:0] addressM,
  output logic [15:0] pc
);
  logic [15:0] r_a;
  logic [15:0] r_d;
  logic [15:0] r_pc;
  logic [15:0] w_y;
  logic [15:0] w_alu;
  logic        w_zr;
  logic        w_ng;
  logic        w_is_c;
  logic        w_jump;

  assign w_is_c = instruction[15];
  assign w_y    = instruction[12] ? inM : r_a;

  alu u_alu (
    .x  (r_d),
    .y  (w_y),
    .zx (instruction[11]),
    .nx (instruction[10]),
    .zy (instruction[9]),
    .ny (instruction[8]),
    .f  (instruction[7]),
    .no (instruction[6]),
    .out(w_alu),
    .zr (w_zr),
    .ng (w_ng)
  );

  assign w_jump = w_is_c & ((instruction[2] & w_ng) |
                            (instruction[1] & w_zr) |
                            (instruction[0] & ~w_ng & ~w_zr));

  assign outM     = w_alu;
  assign writeM   = rst_n & en & w_is_c & instruction[3];
  assign addressM = r_a;
  assign pc       = r_pc;

  // Architectural state; a jump targets the A value from before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a  <= 16'h0000;
      r_d  <= 16'h0000;
      r_pc <= 16'h0000;
    end else if (en) begin
      r_pc <= w_jump ? r_a : (r_pc + 16'h0001);
      if (!w_is_c) begin
        r_a <= {1'b0, instruction[14:0]};
      end else if (instruction[5]) begin
        r_a <= w_alu;
      end else begin
        r_a <= r_a;
      end
      if (w_is_c && instruction[4]) begin
        r_d <= w_alu;
      end else begin
        r_d <= r_d;
      end
    end else begin
      r_a  <= r_a;
      r_d  <= r_d;
      r_pc <= r_pc;
    end
  end
endmodule

// File: tb/tb_hack_cpu_core.sv
// Directed bench for hack_cpu_core: an instruction-level model checked every
// cycle, plus hand-computed literal expectations from the test plan.

module tb_hack_cpu_core;
  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] instruction;
  logic [15:0] inM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] addressM;
  logic [15:0] pc;

  int n_vec;
  int n_bad;

  logic [15:0] m_a;
  logic [15:0] m_d;
  logic [15:0] m_pc;

  hack_cpu_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .instruction(instruction),
    .inM        (inM),
    .outM       (outM),
    .writeM     (writeM),
    .addressM   (addressM),
    .pc         (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hack comp semantics with plain integer arithmetic (complement = 65535 - v).
  function automatic logic [15:0] alu_model(input logic [15:0] x, input logic [15:0] y,
                                            input logic [5:0] c);
    int xv;
    int yv;
    int r;
    logic [31:0] rb;
    xv = c[5] ? 0 : int'(x);
    if (c[4]) xv = 65535 - xv;
    yv = c[3] ? 0 : int'(y);
    if (c[2]) yv = 65535 - yv;
    if (c[1]) r = (xv + yv) % 65536;
    else      r = xv & yv;
    if (c[0]) r = 65535 - r;
    rb = r;
    return rb[15:0];
  endfunction

  function automatic logic [15:0] exp_out();
    return alu_model(m_d, instruction[12] ? inM : m_a, instruction[11:6]);
  endfunction

  function automatic logic exp_jump();
    logic signed [15:0] s;
    s = exp_out();
    return instruction[15] && ((instruction[2] && s < 0) ||
                               (instruction[1] && s == 0) ||
                               (instruction[0] && s > 0));
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level reference model.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a  <= 16'h0000;
      m_d  <= 16'h0000;
      m_pc <= 16'h0000;
    end else if (en) begin
      m_pc <= exp_jump() ? m_a : 16'((int'(m_pc) + 1) % 65536);
      if (!instruction[15])       m_a <= {1'b0, instruction[14:0]};
      else if (instruction[5])    m_a <= exp_out();
      if (instruction[15] && instruction[4]) m_d <= exp_out();
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    chk("outM", outM, exp_out());
    chk("writeM", {15'd0, writeM}, {15'd0, rst_n & en & instruction[15] & instruction[3]});
    chk("addressM", addressM, m_a);
    chk("pc", pc, m_pc);
  end

  task automatic drive(input logic [15:0] instr, input logic [15:0] inm, input logic e);
    instruction = instr;
    inM = inm;
    en = e;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [15:0] instr, input logic [15:0] inm);
    drive(instr, inm, 1'b1);
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    en = 1'b0;
    instruction = 16'h0000;
    inM = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_addr", addressM, 16'h0000);
    rst_n = 1'b1;

    // 1: preload A=0x1234, D=0x0042, pc=5, then reset mid-cycle
    run(16'h1234, 16'h0000);
    run(16'hEC10, 16'h0000);
    run(16'h0042, 16'h0000);
    run(16'hEC10, 16'h0000);
    run(16'h1234, 16'h0000);
    chk("pre_pc", pc, 16'h0005);
    chk("pre_a", addressM, 16'h1234);
    drive(16'hE308, 16'h0000, 1'b1);
    chk("pre_d_outM", outM, 16'h0042);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_pc", pc, 16'h0000);
    chk("async_addr", addressM, 16'h0000);
    chk("async_wr", {15'd0, writeM}, 16'h0000);
    tick();
    rst_n = 1'b1;
    drive(16'h0000, 16'h0000, 1'b1);
    tick();
    chk("post_rst_pc", pc, 16'h0001);

    // 2: @21 then D=A
    run(16'h0015, 16'h0000);
    run(16'hEC10, 16'h0000);
    chk("t2_a", addressM, 16'd21);
    chk("t2_pc", pc, 16'h0003);
    drive(16'hE300, 16'h0000, 1'b1);
    chk("t2_d", outM, 16'd21);

    // 3: M=D+1 at A=100
    run(16'd100, 16'h0000);
    drive(16'hE7C8, 16'h0000, 1'b1);
    chk("t3_outM", outM, 16'd22);
    chk("t3_wr", {15'd0, writeM}, 16'h0001);
    chk("t3_addr", addressM, 16'd100);
    tick();
    chk("t3_pc", pc, 16'h0005);
    chk("t3_a", addressM, 16'd100);

    // 4: conditional and unconditional jumps
    run(16'hEE90, 16'h0000);
    run(16'd40, 16'h0000);
    run(16'hE301, 16'h0000);
    chk("jgt_neg", pc, 16'h0008);
    run(16'd5, 16'h0000);
    run(16'hEC10, 16'h0000);
    run(16'd40, 16'h0000);
    run(16'hE301, 16'h0000);
    chk("jgt_pos", pc, 16'd40);
    run(16'h0123, 16'h0000);
    run(16'hEA87, 16'h0000);
    chk("jmp", pc, 16'h0123);

    // 5: AM=M-1;JEQ with A=7, inM=1
    run(16'd7, 16'h0000);
    drive(16'hFCAA, 16'h0001, 1'b1);
    chk("t5_outM", outM, 16'h0000);
    chk("t5_wr", {15'd0, writeM}, 16'h0001);
    chk("t5_addr", addressM, 16'd7);
    tick();
    chk("t5_pc", pc, 16'd7);
    chk("t5_a", addressM, 16'h0000);

    // 6: stall, then wrap from 0xFFFF
    drive(16'hEC10, 16'h0000, 1'b0);
    chk("stall_wr", {15'd0, writeM}, 16'h0000);
    repeat (3) tick();
    chk("stall_pc", pc, 16'd7);
    chk("stall_a", addressM, 16'h0000);
    drive(16'hE7C8, 16'h0000, 1'b0);
    chk("stall_mwr", {15'd0, writeM}, 16'h0000);
    tick();
    chk("stall_pc2", pc, 16'd7);
    run(16'hEE90, 16'h0000);
    run(16'hE320, 16'h0000);
    chk("a_ffff", addressM, 16'hFFFF);
    run(16'hEA87, 16'h0000);
    chk("pc_ffff", pc, 16'hFFFF);
    run(16'hEC10, 16'h0000);
    chk("pc_wrap", pc, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
